// File: rtl/register_file_mp.sv
// Multi-port register file with per-byte write merging, optional write-first bypass,
// optional registered read and a one-entry-per-cycle clear sweep.
module register_file_mp #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int RD_REG   = 0,
  localparam int AW      = $clog2(DEPTH),
  localparam int NB      = DATA_W / 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*AW-1:0]     wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_WR*NB-1:0]     wr_be,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done
);

  localparam logic [1:0]    S_IDLE  = 2'd0;
  localparam logic [1:0]    S_CLEAR = 2'd1;
  localparam logic [1:0]    S_DONE  = 2'd2;
  localparam logic [AW:0]   LIM     = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [1:0]        r_state;
  logic [AW-1:0]     r_ptr;
  logic              w_busy;
  logic [NUM_WR-1:0] w_wr_eff;

  assign w_busy   = (r_state == S_CLEAR);
  assign clr_busy = w_busy;
  assign clr_done = (r_state == S_DONE);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WR; gi++) begin : g_eff
      logic [AW-1:0] w_wa;
      assign w_wa = wr_addr[gi*AW +: AW];
      assign w_wr_eff[gi] = wr_en[gi] && !w_busy && ({1'b0, w_wa} < LIM) &&
                            !((ZERO_REG != 0) && (w_wa == '0));
    end
  endgenerate

  // Later ports overwrite earlier ones byte by byte, so the highest port wins per byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < DEPTH; e++) r_mem[e] <= '0;
    end else if (w_busy) begin
      r_mem[r_ptr] <= '0;
    end else begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (w_wr_eff[p]) begin
          for (int b = 0; b < NB; b++) begin
            if (wr_be[p*NB + b])
              r_mem[wr_addr[p*AW +: AW]][b*8 +: 8] <= wr_data[p*DATA_W + b*8 +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (clr_req) begin
            r_state <= S_CLEAR;
            r_ptr   <= '0;
          end
        end
        S_CLEAR: begin
          if (r_ptr == LAST) r_state <= S_DONE;
          else               r_ptr   <= r_ptr + AW'(1);
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_ptr   <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [AW-1:0]     w_ra;
      logic [DATA_W-1:0] w_val;
      assign w_ra = rd_addr[gi*AW +: AW];

      // Clear writes never count as effective, so they are never forwarded.
      always_comb begin
        w_val = '0;
        if (({1'b0, w_ra} < LIM) && !((ZERO_REG != 0) && (w_ra == '0))) begin
          w_val = r_mem[w_ra];
          if (BYPASS != 0) begin
            for (int p = 0; p < NUM_WR; p++) begin
              if (w_wr_eff[p] && (wr_addr[p*AW +: AW] == w_ra)) begin
                for (int b = 0; b < NB; b++) begin
                  if (wr_be[p*NB + b])
                    w_val[b*8 +: 8] = wr_data[p*DATA_W + b*8 +: 8];
                end
              end
            end
          end
        end
      end

      if (RD_REG != 0) begin : g_reg
        logic [DATA_W-1:0] r_rd;
        always_ff @(posedge clk or posedge rst) begin
          if (rst) r_rd <= '0;
          else     r_rd <= w_val;
        end
        assign rd_data[gi*DATA_W +: DATA_W] = r_rd;
      end else begin : g_comb
        assign rd_data[gi*DATA_W +: DATA_W] = w_val;
      end
    end
  endgenerate

endmodule

// File: doc/register_file_mp.md
# register_file_mp

Parametrised multi-port register file: configurable width, depth, read/write port count, optional hard-wired zero entry, write-to-read bypass, optional registered read, byte-enabled writes and a sequenced clear engine. It is the general-purpose architectural/configuration register store, instantiated wherever a core or peripheral needs several simultaneous reads and writes per cycle.

## Interface
- DATA_W, 32: entry width in bits; must be a multiple of 8.
- DEPTH, 32: number of entries, at least 2; AW = $clog2(DEPTH).
- NUM_RD, 2: read ports, at least 1.
- NUM_WR, 1: write ports, at least 1.
- ZERO_REG, 1: 1 = entry 0 reads 0 and ignores writes.
- BYPASS, 1: 1 = same-cycle write data forwarded to matching reads.
- RD_REG, 0: 0 = combinational read; 1 = registered read, latency 1.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  NUM_WR  per-port write enable.
- wr_addr  in  NUM_WR*AW  write address; port i occupies slice i.
- wr_data  in  NUM_WR*DATA_W  write data.
- wr_be  in  NUM_WR*DATA_W/8  byte enables; bit b covers data bits [8b+7:8b].
- rd_addr  in  NUM_RD*AW  read addresses.
- rd_data  out  NUM_RD*DATA_W  read data.
- clr_req  in  1  request to zero every entry.
- clr_busy  out  1  high while the clear sweep runs.
- clr_done  out  1  one-cycle pulse when the sweep completes.

## Operation
- Reset: all entries 0, rd_data 0 when RD_REG=1, FSM IDLE, clr_busy 0, clr_done 0, sweep pointer 0.
- A write port is effective when wr_en[i]=1, clr_busy=0, wr_addr<DEPTH, and not (ZERO_REG=1 and wr_addr=0).
- Only bytes with wr_be set are updated; all-zero wr_be means no change.
- Several ports hitting the same address: merged per byte; the highest-index port with that byte enabled wins.
- Reads: rd_addr>=DEPTH returns 0; entry 0 returns 0 when ZERO_REG=1.
- BYPASS=1: a read whose address matches an effective write this cycle returns the merged post-write value: write-first.
- BYPASS=0: such a read returns the stored pre-write value: read-first.
- Clear FSM, with states IDLE, CLEAR and DONE:
  - IDLE: clr_req=1 goes to CLEAR with ptr=0.
  - CLEAR: entry[ptr] is written to 0 each cycle and ptr increments. When ptr=DEPTH-1, that entry is zeroed and the FSM goes to DONE.
  - DONE: clr_done=1 for this cycle only; the FSM returns to IDLE.
- clr_busy=1 exactly in CLEAR.
- clr_req is ignored in CLEAR and DONE; it is level-sampled in IDLE. A held clr_req restarts the sweep after DONE.
- All write ports are ignored during CLEAR. Reads stay live during CLEAR and return partially cleared contents. Bypass does not forward clear writes.
- rst asserted mid-sweep: immediate abort to IDLE, with all entries 0 and flags 0.

## Timing
- Write latency: data is stored at the rising edge where the write is effective. Without bypass, it is visible on combinational reads from the next cycle.
- RD_REG=0: rd_data is combinational from rd_addr, plus wr_* when BYPASS=1.
- RD_REG=1: rd_data is registered at the edge after rd_addr is presented. Registered output follows the same bypass rule, applied to the write in the cycle the address was sampled.
- Clear: clr_req sampled at edge t gives clr_busy high for cycles t+1 .. t+DEPTH and clr_done high in cycle t+DEPTH+1. Writes resume in cycle t+DEPTH+1.

## Test plan
- Reset then read all addresses on every read port -> every rd_data is 0. clr_busy=0, clr_done=0.
- Port 0 writes 0xDEADBEEF to address 5 with be=4'b1111, then be=4'b0011 with 0x00001234 -> address 5 reads 0xDEAD1234 next cycle on all read ports.
- NUM_WR=2, both ports write address 7 in the same cycle. Port0 data 0x11111111 with be=1111; port1 data 0x22222222 with be=0101. -> address 7 = 0x11221122.
- BYPASS=1, RD_REG=0: write 0xA5A5A5A5 to address 3 while reading address 3 in the same cycle -> rd_data=0xA5A5A5A5 that cycle. With BYPASS=0 -> the old value.
- ZERO_REG=1: write 0xFFFFFFFF to address 0 -> reads 0. Read of address >= DEPTH (DEPTH=24) -> 0.
- Fill entries with nonzero values, then pulse clr_req for one cycle -> clr_busy high for DEPTH cycles, with a concurrent write ignored. clr_done then pulses once and all entries read 0. Repeat with rst asserted mid-sweep -> FSM IDLE and flags 0 immediately.
